multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main sequencer of the multi-cycle core: steps every instruction through IF/ID/EX/MEM/WB.
//  Drives control_status and the registered jump/zero redirect pair into the program counter.
//  Handshakes instruction and data memory, supplies datapath write strobes and mux selects.
//  Sits between the instruction register/decoder and the PC, register file, ALU and memories.
// PARAMETERS
//  MAX_WAIT  16  wait cycles allowed per memory access before bus_err; range 1..255
// PORTS
//  clk             in   1  core clock; all state changes on posedge
//  rst_n           in   1  asynchronous, active-low reset
//  opcode          in   6  instr[31:26] from the instruction register
//  funct           in   6  instr[5:0]; used only when opcode==6'h00
//  alu_zero        in   1  ALU zero flag, valid in EX
//  imem_ready      in   1  instruction memory completes the fetch this cycle
//  dmem_ready      in   1  data memory completes the access this cycle
//  imem_req        out  1  fetch request; held high through IF until imem_ready
//  dmem_req        out  1  data access request; held high through MEM until dmem_ready
//  dmem_we         out  1  data access is a store; qualified by dmem_req
//  control_status  out  3  phase code from define.v (`IF `ID `EX `MEM `WB `STALL `HALT `BOOT)
//  jump            out  1  registered PC redirect request
//  zero            out  1  registered redirect select: 1 = branch_pc, 0 = jump_pc
//  ir_we           out  1  instruction register load strobe
//  reg_we          out  1  register file write strobe
//  reg_dst         out  2  write register select: 0=rt, 1=rd, 2=$31
//  mem_to_reg      out  1  write-back data from dmem, not ALU
//  alu_src         out  1  ALU B operand is sign-extended immediate
//  jr_sel          out  1  jump_pc comes from rs, not the J-target
//  bus_err         out  1  sticky: memory wait exceeded MAX_WAIT
//  illegal         out  1  sticky: undecoded opcode/funct seen in ID
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): state=BOOT, jump=0, zero=0, bus_err=0, illegal=0, wait_cnt=0.
//   In BOOT all strobes and requests are 0, control_status=`BOOT.
//   BOOT moves to IF on the first clock after release.
//  control_status equals the state code, with two exceptions:
//   In IF or MEM with ready low it reads `STALL.
//   The PC therefore advances exactly once per fetch: on the edge ending the IF cycle with imem_ready=1.
//  IF: imem_req=1. On imem_ready: ir_we=1 that cycle; jump and zero clear at that edge; next state ID.
//  ID: decode only, one cycle. Next state EX; an illegal instruction goes to IF and sets illegal.
//  EX: alu_src and jr_sel are driven this cycle. At the closing edge jump/zero load:
//   BEQ (04): jump=alu_zero, zero=1.
//   BNE (05): jump=~alu_zero, zero=1.
//   J (02), JAL (03), JR (00/08): jump=1, zero=0.
//   All other opcodes: jump=0.
//  Phase sequences:
//   R-type, ADDI (08), JAL: IF ID EX WB.
//   LW (23): IF ID EX MEM WB.
//   SW (2B): IF ID EX MEM.
//   BEQ, BNE, J, JR: IF ID EX.
//  MEM: dmem_req=1, dmem_we=1 for SW. Leaves on dmem_ready: LW goes to WB, SW goes to IF.
//  WB: reg_we=1 for one cycle, then IF.
//   LW: mem_to_reg=1, reg_dst=0.
//   ADDI: reg_dst=0.
//   R-type: reg_dst=1.
//   JAL: reg_dst=2.
//   JR never writes.
//  Branch delay slot: jump/zero stay held through MEM/WB and are consumed by the next completing IF.
//   The instruction after a branch or jump always executes.
//  wait_cnt: clears on entry to IF/MEM; increments each ready-low cycle and saturates.
//   At MAX_WAIT ready-low cycles: bus_err=1, state=HALT, all requests and strobes 0.
//   HALT is left only by reset.
//  A ready arriving in the same cycle the count reaches MAX_WAIT completes normally; ready wins.
//  Reset mid-access aborts immediately; requests drop asynchronously with state=BOOT.
// STRUCTURE
//  define.v holds the phase codes (BOOT=7 is new; HALT=6, STALL=5) and the opcode/funct constants.
//  A single always block for the state register and flags, plus combinational output decode.
//  Sub-module ctrl_decode (combinational): {opcode,funct} -> instruction class + mux selects.
// TESTING
//  Release reset, imem_ready=1 -> BOOT, then IF/ID/EX/WB for R-type; reg_we=1, reg_dst=1 only in WB.
//  LW with dmem_ready low 3 cycles -> `STALL x3, dmem_req high 4 cycles, then WB with mem_to_reg=1.
//  BEQ with alu_zero=1 -> jump=1, zero=1 after EX; both held through the delay-slot IF, cleared at its end.
//  BNE with alu_zero=1 -> jump=0; J -> jump=1, zero=0; JAL -> WB with reg_dst=2.
//  imem_ready low 16 cycles (MAX_WAIT=16) -> bus_err=1, `HALT, imem_req=0; ready at cycle 16 completes.
//  opcode 6'h3F -> illegal=1, back to IF after ID; rst_n low mid-MEM -> dmem_req=0, control_status=`BOOT.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_pkg
//  Description : Shared constants and types for the multi-cycle sequencer.
//                Holds the phase codes, the opcode/funct constants, the
//                instruction classes and the decoded-control record.
//  Revision    : 1.0  initial release
// ============================================================================
package multicycle_ctrl_pkg;

    // Phase codes reported on control_status
    localparam logic [2:0] PH_IF    = 3'd0;
    localparam logic [2:0] PH_ID    = 3'd1;
    localparam logic [2:0] PH_EX    = 3'd2;
    localparam logic [2:0] PH_MEM   = 3'd3;
    localparam logic [2:0] PH_WB    = 3'd4;
    localparam logic [2:0] PH_STALL = 3'd5;
    localparam logic [2:0] PH_HALT  = 3'd6;
    localparam logic [2:0] PH_BOOT  = 3'd7;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Write-register selects
    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    // State encoding equals the phase code so status is a direct copy
    typedef enum logic [2:0] {
        ST_IF   = PH_IF,
        ST_ID   = PH_ID,
        ST_EX   = PH_EX,
        ST_MEM  = PH_MEM,
        ST_WB   = PH_WB,
        ST_HALT = PH_HALT,
        ST_BOOT = PH_BOOT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_JR,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_ILLEGAL
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic       alu_src;
        logic       jr_sel;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    // R-type ALU operations the datapath implements
    function automatic logic is_alu_funct(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_decode
//  Description : Combinational instruction decoder. Maps {opcode,funct} to an
//                instruction class and the datapath mux selects.
//  Ports       : i_opcode [5:0]  instr[31:26]
//                i_funct  [5:0]  instr[5:0], meaningful for R-type only
//                o_ctrl          decoded class and selects
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl     = '0;
        o_ctrl.cls = CLS_ILLEGAL;
        case (i_opcode)
            OP_RTYPE: begin
                if (i_funct == FN_JR) begin
                    o_ctrl.cls    = CLS_JR;
                    o_ctrl.jr_sel = 1'b1;
                end else if (is_alu_funct(i_funct)) begin
                    o_ctrl.cls     = CLS_ALU_R;
                    o_ctrl.reg_dst = RD_RD;
                end
            end
            OP_J:   o_ctrl.cls = CLS_J;
            OP_JAL: begin
                o_ctrl.cls     = CLS_JAL;
                o_ctrl.reg_dst = RD_RA;
            end
            OP_BEQ: o_ctrl.cls = CLS_BEQ;
            OP_BNE: o_ctrl.cls = CLS_BNE;
            OP_ADDI: begin
                o_ctrl.cls     = CLS_ADDI;
                o_ctrl.alu_src = 1'b1;
                o_ctrl.reg_dst = RD_RT;
            end
            OP_LW: begin
                o_ctrl.cls        = CLS_LW;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.reg_dst    = RD_RT;
                o_ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                o_ctrl.cls     = CLS_SW;
                o_ctrl.alu_src = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main sequencer of the multi-cycle core. Steps each
//                instruction through IF/ID/EX/MEM/WB, handshakes the
//                instruction and data memories, drives datapath strobes and
//                selects, and holds the registered jump/zero redirect pair.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                opcode, funct, alu_zero    instruction fields, ALU flag
//                imem_ready, dmem_ready     memory completion handshakes
//                imem_req, dmem_req, dmem_we memory requests
//                control_status             phase code (STALL while waiting)
//                jump, zero                 registered PC redirect pair
//                ir_we, reg_we, reg_dst, mem_to_reg, alu_src, jr_sel
//                bus_err, illegal           sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [2:0] control_status,
    output logic       jump,
    output logic       zero,
    output logic       ir_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       jr_sel,
    output logic       bus_err,
    output logic       illegal
);

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    state_t     r_state;
    ctrl_t      r_ctrl;
    logic       r_jump;
    logic       r_zero;
    logic       r_bus_err;
    logic       r_illegal;
    logic [7:0] r_wait_cnt;

    ctrl_t      w_dec;
    logic       w_stall;
    logic [7:0] w_cnt_inc;

    multicycle_ctrl_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_ctrl   (w_dec)
    );

    assign w_stall   = ((r_state == ST_IF)  && !imem_ready) ||
                       ((r_state == ST_MEM) && !dmem_ready);
    assign w_cnt_inc = (r_wait_cnt == c_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_ctrl     <= '0;
            r_jump     <= 1'b0;
            r_zero     <= 1'b0;
            r_bus_err  <= 1'b0;
            r_illegal  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            // Any non-waiting cycle clears the count, so IF/MEM are entered at 0
            if (w_stall) begin
                r_wait_cnt <= w_cnt_inc;
            end else if (r_state != ST_HALT) begin
                r_wait_cnt <= '0;
            end

            case (r_state)
                ST_BOOT: r_state <= ST_IF;

                ST_IF: begin
                    if (imem_ready) begin
                        // Fetch completion consumes the pending redirect
                        r_state <= ST_ID;
                        r_jump  <= 1'b0;
                        r_zero  <= 1'b0;
                    end else if (w_cnt_inc == c_MAX_WAIT) begin
                        r_state   <= ST_HALT;
                        r_bus_err <= 1'b1;
                    end
                end

                ST_ID: begin
                    r_ctrl <= w_dec;
                    if (w_dec.cls == CLS_ILLEGAL) begin
                        r_illegal <= 1'b1;
                        r_state   <= ST_IF;
                    end else begin
                        r_state <= ST_EX;
                    end
                end

                ST_EX: begin
                    case (r_ctrl.cls)
                        CLS_BEQ: begin
                            r_jump <= alu_zero;
                            r_zero <= 1'b1;
                        end
                        CLS_BNE: begin
                            r_jump <= ~alu_zero;
                            r_zero <= 1'b1;
                        end
                        CLS_J, CLS_JAL, CLS_JR: begin
                            r_jump <= 1'b1;
                            r_zero <= 1'b0;
                        end
                        default: r_jump <= 1'b0;
                    endcase
                    case (r_ctrl.cls)
                        CLS_LW, CLS_SW:                r_state <= ST_MEM;
                        CLS_ALU_R, CLS_ADDI, CLS_JAL:  r_state <= ST_WB;
                        default:                       r_state <= ST_IF;
                    endcase
                end

                ST_MEM: begin
                    if (dmem_ready) begin
                        r_state <= (r_ctrl.cls == CLS_LW) ? ST_WB : ST_IF;
                    end else if (w_cnt_inc == c_MAX_WAIT) begin
                        r_state   <= ST_HALT;
                        r_bus_err <= 1'b1;
                    end
                end

                ST_WB:   r_state <= ST_IF;

                ST_HALT: r_state <= ST_HALT;

                default: r_state <= ST_BOOT;
            endcase
        end
    end

    // Strobes decode from state only, so reset drops them asynchronously
    assign imem_req       = (r_state == ST_IF);
    assign ir_we          = (r_state == ST_IF) && imem_ready;
    assign dmem_req       = (r_state == ST_MEM);
    assign dmem_we        = (r_state == ST_MEM) && (r_ctrl.cls == CLS_SW);
    assign alu_src        = (r_state == ST_EX) && r_ctrl.alu_src;
    assign jr_sel         = (r_state == ST_EX) && r_ctrl.jr_sel;
    assign reg_we         = (r_state == ST_WB);
    assign reg_dst        = (r_state == ST_WB) ? r_ctrl.reg_dst : RD_RT;
    assign mem_to_reg     = (r_state == ST_WB) && r_ctrl.mem_to_reg;
    assign control_status = w_stall ? PH_STALL : r_state;
    assign jump           = r_jump;
    assign zero           = r_zero;
    assign bus_err        = r_bus_err;
    assign illegal        = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. A reference model
//                expands each instruction into its expected cycle trace from
//                the phase-sequence rules; directed vectors, random
//                instructions and multi-cycle corner cases are compared.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int MAX_WAIT = 16;

    localparam logic [2:0] P_IF = 3'd0, P_ID = 3'd1, P_EX = 3'd2, P_MEM = 3'd3;
    localparam logic [2:0] P_WB = 3'd4, P_STALL = 3'd5, P_HALT = 3'd6, P_BOOT = 3'd7;

    localparam int K_ALU = 0, K_JR = 1, K_ADDI = 2, K_LW = 3, K_SW = 4;
    localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_JAL = 8, K_BAD = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, dmem_req, dmem_we, jump, zero, ir_we, reg_we;
    logic       mem_to_reg, alu_src, jr_sel, bus_err, illegal;
    logic [2:0] control_status;
    logic [1:0] reg_dst;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode         (opcode),
        .funct          (funct),
        .alu_zero       (alu_zero),
        .imem_ready     (imem_ready),
        .dmem_ready     (dmem_ready),
        .imem_req       (imem_req),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .control_status (control_status),
        .jump           (jump),
        .zero           (zero),
        .ir_we          (ir_we),
        .reg_we         (reg_we),
        .reg_dst        (reg_dst),
        .mem_to_reg     (mem_to_reg),
        .alu_src        (alu_src),
        .jr_sel         (jr_sel),
        .bus_err        (bus_err),
        .illegal        (illegal)
    );

    // One expected cycle: inputs to apply and outputs required
    typedef struct {
        logic       ir, dr, az;
        logic [2:0] status;
        logic       imem_req, dmem_req, dmem_we, ir_we, reg_we;
        logic [1:0] reg_dst;
        logic       mem_to_reg, alu_src, jr_sel, jump, zero, bus_err, illegal;
    } cyc_t;

    // Directed vector: instruction, waits, and observed summary required
    typedef struct {
        logic [5:0] op, fn;
        logic       az;
        int         iw, dw;
        int         phases;
        logic       j, z, ill;
        logic [1:0] dst;   // 3 = no register write expected
        logic       m2r;
    } vec_t;

    typedef logic [2:0] phq_t [$];

    int         n_checks = 0;
    int         n_errors = 0;
    logic       m_jump, m_zero, m_bus_err, m_illegal;
    int         obs_phases;
    logic [1:0] obs_dst;
    logic       obs_m2r;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int klass(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] alu_fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        case (op)
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                foreach (alu_fns[i]) if (fn == alu_fns[i]) return K_ALU;
                return K_BAD;
            end
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            6'h04:   return K_BEQ;
            6'h05:   return K_BNE;
            6'h08:   return K_ADDI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            default: return K_BAD;
        endcase
    endfunction

    function automatic phq_t phase_list(input int k);
        case (k)
            K_ALU, K_ADDI, K_JAL: return '{P_IF, P_ID, P_EX, P_WB};
            K_LW:                 return '{P_IF, P_ID, P_EX, P_MEM, P_WB};
            K_SW:                 return '{P_IF, P_ID, P_EX, P_MEM};
            K_BAD:                return '{P_IF, P_ID};
            default:              return '{P_IF, P_ID, P_EX};
        endcase
    endfunction

    // Idle cycle with random (irrelevant) inputs and current sticky model state
    function automatic cyc_t base(input logic [2:0] st);
        cyc_t c;
        c.ir = 1'($urandom); c.dr = 1'($urandom); c.az = 1'($urandom);
        c.status = st;
        c.imem_req = 0; c.dmem_req = 0; c.dmem_we = 0; c.ir_we = 0; c.reg_we = 0;
        c.reg_dst = 0; c.mem_to_reg = 0; c.alu_src = 0; c.jr_sel = 0;
        c.jump = m_jump; c.zero = m_zero; c.bus_err = m_bus_err; c.illegal = m_illegal;
        return c;
    endfunction

    task automatic compare(input cyc_t c);
        chk("status",     control_status,   c.status);
        chk("imem_req",   3'(imem_req),     3'(c.imem_req));
        chk("dmem_req",   3'(dmem_req),     3'(c.dmem_req));
        chk("dmem_we",    3'(dmem_we),      3'(c.dmem_we));
        chk("ir_we",      3'(ir_we),        3'(c.ir_we));
        chk("reg_we",     3'(reg_we),       3'(c.reg_we));
        chk("reg_dst",    3'(reg_dst),      3'(c.reg_dst));
        chk("mem_to_reg", 3'(mem_to_reg),   3'(c.mem_to_reg));
        chk("alu_src",    3'(alu_src),      3'(c.alu_src));
        chk("jr_sel",     3'(jr_sel),       3'(c.jr_sel));
        chk("jump",       3'(jump),         3'(c.jump));
        chk("zero",       3'(zero),         3'(c.zero));
        chk("bus_err",    3'(bus_err),      3'(c.bus_err));
        chk("illegal",    3'(illegal),      3'(c.illegal));
    endtask

    // Entered at posedge+1; inputs applied, outputs sampled at negedge
    task automatic step(input cyc_t c);
        imem_ready = c.ir;
        dmem_ready = c.dr;
        alu_zero   = c.az;
        @(negedge clk);
        compare(c);
        if (control_status != P_STALL) obs_phases++;
        if (reg_we === 1'b1) begin
            obs_dst = reg_dst;
            obs_m2r = mem_to_reg;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_jump = 0; m_zero = 0; m_bus_err = 0; m_illegal = 0;
        @(posedge clk);
        #1;
        compare(base(P_BOOT));
        rst_n = 1'b1;
        step(base(P_BOOT));
    endtask

    // Expand one instruction into its expected trace, then run `limit` cycles of it
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int iw, input int dw, input logic az_ex, input int limit);
        cyc_t tr[$];
        cyc_t c;
        phq_t pl;
        int   k;
        k = klass(op, fn);
        pl = phase_list(k);
        opcode = op;
        funct  = fn;
        foreach (pl[i]) begin
            case (pl[i])
                P_IF: begin
                    for (int w = 0; w < iw; w++) begin
                        c = base(P_STALL); c.ir = 0; c.imem_req = 1; tr.push_back(c);
                    end
                    c = base(P_IF); c.ir = 1; c.imem_req = 1; c.ir_we = 1; tr.push_back(c);
                    m_jump = 0; m_zero = 0;
                end
                P_ID: begin
                    tr.push_back(base(P_ID));
                    if (k == K_BAD) m_illegal = 1;
                end
                P_EX: begin
                    c = base(P_EX);
                    c.az = az_ex;
                    c.alu_src = (k == K_ADDI) || (k == K_LW) || (k == K_SW);
                    c.jr_sel  = (k == K_JR);
                    tr.push_back(c);
                    if (k == K_BEQ) begin m_jump = az_ex; m_zero = 1; end
                    else if (k == K_BNE) begin m_jump = !az_ex; m_zero = 1; end
                    else if (k == K_J || k == K_JAL || k == K_JR) begin m_jump = 1; m_zero = 0; end
                    else m_jump = 0;
                end
                P_MEM: begin
                    for (int w = 0; w < dw; w++) begin
                        c = base(P_STALL); c.dr = 0; c.dmem_req = 1; c.dmem_we = (k == K_SW);
                        tr.push_back(c);
                    end
                    c = base(P_MEM); c.dr = 1; c.dmem_req = 1; c.dmem_we = (k == K_SW);
                    tr.push_back(c);
                end
                default: begin
                    c = base(P_WB);
                    c.reg_we = 1;
                    c.reg_dst = (k == K_ALU) ? 2'd1 : (k == K_JAL) ? 2'd2 : 2'd0;
                    c.mem_to_reg = (k == K_LW);
                    tr.push_back(c);
                end
            endcase
        end
        obs_phases = 0;
        obs_dst    = 2'b11;
        obs_m2r    = 1'b0;
        for (int i = 0; i < tr.size(); i++) begin
            if (limit >= 0 && i >= limit) break;
            step(tr[i]);
        end
    endtask

    vec_t       vt [13];
    logic [5:0] rnd_ops [11] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                 6'h08, 6'h23, 6'h2B, 6'h3F, 6'h11};
    logic [5:0] rnd_fns [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h08, 6'h01};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_t c;
        //          op     fn     az  iw  dw  ph  j  z  ill dst m2r
        vt[0]  = '{6'h00, 6'h20, 0,  0,  0,  4,  0, 0, 0,  1,  0};
        vt[1]  = '{6'h23, 6'h00, 0,  1,  3,  5,  0, 0, 0,  0,  1};
        vt[2]  = '{6'h04, 6'h00, 1,  0,  0,  3,  1, 1, 0,  3,  0};
        vt[3]  = '{6'h08, 6'h00, 0,  2,  0,  4,  0, 0, 0,  0,  0};
        vt[4]  = '{6'h05, 6'h00, 1,  0,  0,  3,  0, 1, 0,  3,  0};
        vt[5]  = '{6'h05, 6'h00, 0,  0,  0,  3,  1, 1, 0,  3,  0};
        vt[6]  = '{6'h04, 6'h00, 0,  1,  0,  3,  0, 1, 0,  3,  0};
        vt[7]  = '{6'h02, 6'h00, 0,  0,  0,  3,  1, 0, 0,  3,  0};
        vt[8]  = '{6'h03, 6'h00, 0, 15,  0,  4,  1, 0, 0,  2,  0};
        vt[9]  = '{6'h00, 6'h08, 0,  0,  0,  3,  1, 0, 0,  3,  0};
        vt[10] = '{6'h2B, 6'h00, 0,  0, 15,  4,  0, 0, 0,  3,  0};
        vt[11] = '{6'h00, 6'h3F, 0,  0,  0,  2,  0, 0, 1,  3,  0};
        vt[12] = '{6'h3F, 6'h00, 0,  3,  0,  2,  0, 0, 1,  3,  0};

        do_reset();

        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].fn, vt[i].iw, vt[i].dw, vt[i].az, -1);
            chk("vec_phases",  3'(obs_phases), 3'(vt[i].phases));
            chk("vec_jump",    3'(jump),       3'(vt[i].j));
            chk("vec_zero",    3'(zero),       3'(vt[i].z));
            chk("vec_illegal", 3'(illegal),    3'(vt[i].ill));
            chk("vec_wb_dst",  3'(obs_dst),    3'(vt[i].dst));
            chk("vec_wb_m2r",  3'(obs_m2r),    3'(vt[i].m2r));
        end

        do_reset();
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op, fn;
            int iw, dw;
            op = rnd_ops[$urandom_range(0, 10)];
            fn = (op == 6'h00) ? rnd_fns[$urandom_range(0, 8)] : 6'($urandom);
            iw = ($urandom_range(0, 9) == 0) ? MAX_WAIT - 1 : $urandom_range(0, 3);
            dw = ($urandom_range(0, 9) == 0) ? MAX_WAIT - 1 : $urandom_range(0, 3);
            run_instr(op, fn, iw, dw, 1'($urandom), -1);
        end

        // Reset while a load is waiting in MEM
        do_reset();
        run_instr(6'h23, 6'h00, 0, 8, 1'b0, 5);
        dmem_ready = 1'b0;
        #2;
        chk("pre_rst_dmem_req", 3'(dmem_req), 3'd1);
        rst_n = 1'b0;
        #1;
        m_jump = 0; m_zero = 0; m_bus_err = 0; m_illegal = 0;
        compare(base(P_BOOT));
        do_reset();

        // Instruction fetch never completes
        for (int w = 0; w < MAX_WAIT; w++) begin
            c = base(P_STALL); c.ir = 0; c.imem_req = 1; step(c);
        end
        m_bus_err = 1;
        for (int w = 0; w < 3; w++) begin
            c = base(P_HALT); c.ir = 1; c.dr = 1; step(c);
        end

        // Store never completes
        do_reset();
        run_instr(6'h2B, 6'h00, 0, 99, 1'b0, 3);
        for (int w = 0; w < MAX_WAIT; w++) begin
            c = base(P_STALL); c.dr = 0; c.dmem_req = 1; c.dmem_we = 1; step(c);
        end
        m_bus_err = 1;
        for (int w = 0; w < 3; w++) begin
            c = base(P_HALT); c.ir = 1; c.dr = 1; step(c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
